// File: rtl/lui_cpu_sequencer_pkg.sv
// rtl/lui_cpu_sequencer_pkg.sv - shared types and constants for the LUI CPU sequencer
// Contents: FSM state enum, opcode constants, ALUOp encoding, fault codes.
package lui_cpu_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_FAULT  = 3'd6
  } state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] ALUOP_PASS_IMM = 2'b01;

  localparam logic [1:0] FAULT_NONE    = 2'd0;
  localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
  localparam logic [1:0] FAULT_TIMEOUT = 2'd2;

endpackage

// File: rtl/lui_seq_fetch_if.sv
// rtl/lui_seq_fetch_if.sv - instruction fetch handshake, IR capture and fetch timeout
// Ports:
//   clk, rst       clock, async active-low reset
//   start          pulse on the edge that enters FETCH; clears the timeout counter
//   active         FSM is in FETCH
//   imem_req       fetch request (high for the whole FETCH state)
//   imem_ack       fetch complete, imem_rdata valid
//   imem_rdata     fetched word
//   instr          instruction register
//   done           ack seen during FETCH (IR loads on this edge)
//   timeout        last permitted FETCH cycle passed without ack
module lui_seq_fetch_if #(
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        active,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        done,
  output logic        timeout
);

  // cnt holds the number of FETCH cycles already spent without ack, so the
  // FETCH_TIMEOUT-th waiting cycle is the one that raises timeout.
  localparam logic [7:0] CNT_LAST = 8'(FETCH_TIMEOUT - 1);

  logic [7:0] cnt;

  assign imem_req = active;
  assign done     = active && imem_ack;
  assign timeout  = active && !imem_ack && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 8'd0;
    end else if (start) begin
      cnt <= 8'd0;
    end else if (active && !imem_ack && !timeout) begin
      cnt <= cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr <= 32'd0;
    end else if (done) begin
      instr <= imem_rdata;
    end
  end

endmodule

// File: rtl/lui_cpu_sequencer.sv
// rtl/lui_cpu_sequencer.sv - multi-cycle control FSM for the single-instruction LUI CPU
// Ports:
//   clk, rst                    clock, async active-low reset
//   run                         enable, sampled in IDLE and at WB
//   imem_req/addr/ack/rdata     instruction memory fetch handshake
//   instr                       IR to datapath
//   reg_write, alu_src, alu_op  datapath controls
//   pc                          program counter
//   busy, halted, fault_code    status
//   retired_count               saturating count of retired LUIs
module lui_cpu_sequencer
  import lui_cpu_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          PC_STEP       = 4,
  parameter int          FETCH_TIMEOUT = 15,
  parameter int          CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic             reg_write,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic [31:0]      pc,
  output logic             busy,
  output logic             halted,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] retired_count
);

  state_t state, state_next;
  logic   fetch_start, fetch_active, fetch_done, fetch_timeout;

  lui_seq_fetch_if #(
    .FETCH_TIMEOUT(FETCH_TIMEOUT)
  ) u_fetch (
    .clk       (clk),
    .rst       (rst),
    .start     (fetch_start),
    .active    (fetch_active),
    .imem_req  (imem_req),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .instr     (instr),
    .done      (fetch_done),
    .timeout   (fetch_timeout)
  );

  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:   if (run) state_next = ST_FETCH;
      ST_FETCH: begin
        if (fetch_done)         state_next = ST_DECODE;
        else if (fetch_timeout) state_next = ST_FAULT;
      end
      ST_DECODE: begin
        if (instr[6:0] == OPC_LUI)         state_next = ST_EXEC;
        else if (instr[6:0] == OPC_SYSTEM) state_next = ST_HALT;
        else                               state_next = ST_FAULT;
      end
      ST_EXEC:   state_next = ST_WB;
      ST_WB:     state_next = run ? ST_FETCH : ST_IDLE;
      ST_HALT:   state_next = ST_HALT;
      ST_FAULT:  state_next = ST_FAULT;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    reg_write    = 1'b0;
    alu_src      = 1'b0;
    alu_op       = 2'b00;
    busy         = 1'b0;
    halted       = 1'b0;
    fetch_active = 1'b0;
    fetch_start  = (state != ST_FETCH) && (state_next == ST_FETCH);
    unique case (state)
      ST_FETCH: begin
        busy         = 1'b1;
        fetch_active = 1'b1;
      end
      ST_DECODE: busy = 1'b1;
      ST_EXEC: begin
        busy    = 1'b1;
        alu_src = 1'b1;
        alu_op  = ALUOP_PASS_IMM;
      end
      ST_WB: begin
        busy      = 1'b1;
        alu_src   = 1'b1;
        alu_op    = ALUOP_PASS_IMM;
        reg_write = 1'b1;
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  // Architectural state advances only on WB exit, so an aborted or faulting
  // instruction leaves pc pointing at itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc            <= RESET_PC;
      retired_count <= '0;
      fault_code    <= FAULT_NONE;
    end else begin
      if (state == ST_WB) begin
        pc <= pc + 32'(PC_STEP);
        if (retired_count != '1) retired_count <= retired_count + CNT_W'(1);
      end
      if (state == ST_FETCH && !fetch_done && fetch_timeout) begin
        fault_code <= FAULT_TIMEOUT;
      end
      if (state == ST_DECODE && state_next == ST_FAULT) begin
        fault_code <= FAULT_ILLEGAL;
      end
    end
  end

endmodule

// File: tb/tb_lui_cpu_sequencer.sv
// tb/tb_lui_cpu_sequencer.sv - directed self-checking bench for lui_cpu_sequencer
module tb_lui_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst, run, imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_req, reg_write, alu_src, busy, halted;
  logic [31:0] imem_addr, instr, pc;
  logic [1:0]  alu_op, fault_code;
  logic [15:0] retired_count;

  logic        w_rst, w_run, w_imem_ack;
  logic [31:0] w_imem_rdata;
  logic        w_imem_req, w_reg_write, w_alu_src, w_busy, w_halted;
  logic [31:0] w_imem_addr, w_instr, w_pc;
  logic [1:0]  w_alu_op, w_fault_code;
  logic [15:0] w_retired_count;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  lui_cpu_sequencer dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .reg_write(reg_write), .alu_src(alu_src), .alu_op(alu_op),
    .pc(pc), .busy(busy), .halted(halted), .fault_code(fault_code), .retired_count(retired_count)
  );

  lui_cpu_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(w_rst), .run(w_run),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ack(w_imem_ack), .imem_rdata(w_imem_rdata),
    .instr(w_instr), .reg_write(w_reg_write), .alu_src(w_alu_src), .alu_op(w_alu_op),
    .pc(w_pc), .busy(w_busy), .halted(w_halted), .fault_code(w_fault_code),
    .retired_count(w_retired_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    w_rst = 1'b0; w_run = 1'b0; w_imem_ack = 1'b0; w_imem_rdata = 32'd0;

    // 1: reset state, then a zero-wait LUI x5,0x12345
    do_reset();
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_ctl", {28'd0, reg_write, alu_src, alu_op}, 32'd0);
    check("rst_status", {29'd0, halted, fault_code}, 32'd0);
    check("rst_retired", {16'd0, retired_count}, 32'd0);
    run = 1'b1;
    tick();                                    // cycle 1: FETCH
    check("t1_req", {31'd0, imem_req}, 32'd1);
    check("t1_addr", imem_addr, 32'h0);
    check("t1_busy", {31'd0, busy}, 32'd1);
    imem_ack = 1'b1; imem_rdata = 32'h1234_52B7;
    tick();                                    // cycle 2: DECODE
    imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    check("t1_req_drop", {31'd0, imem_req}, 32'd0);
    check("t1_ir", instr, 32'h1234_52B7);
    check("t1_dec_ctl", {28'd0, reg_write, alu_src, alu_op}, 32'd0);
    tick();                                    // cycle 3: EXEC
    check("t1_exec_ctl", {28'd0, reg_write, alu_src, alu_op}, 32'b0101);
    tick();                                    // cycle 4: WB
    check("t1_wb_ctl", {28'd0, reg_write, alu_src, alu_op}, 32'b1101);
    check("t1_rd", {27'd0, instr[11:7]}, 32'd5);
    check("t1_pc_wb", pc, 32'h0);
    run = 1'b0;
    tick();                                    // IDLE
    check("t1_wr_once", {31'd0, reg_write}, 32'd0);
    check("t1_pc", pc, 32'h4);
    check("t1_retired", {16'd0, retired_count}, 32'd1);
    check("t1_idle", {30'd0, busy, imem_req}, 32'd0);

    // 2: ack delayed 3 cycles, then 3: SYSTEM after one LUI
    do_reset();
    run = 1'b1;
    tick();
    for (int i = 1; i <= 3; i++) begin
      check($sformatf("t2_wait_req%0d", i), {31'd0, imem_req}, 32'd1);
      check($sformatf("t2_wait_addr%0d", i), imem_addr, 32'h0);
      check($sformatf("t2_wait_ir%0d", i), instr, 32'h0);
      imem_rdata = 32'hAAAA_0000 | i;          // garbage without ack must not load
      tick();
    end
    check("t2_req4", {31'd0, imem_req}, 32'd1);
    check("t2_addr4", imem_addr, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'h1234_52B7;
    tick();                                    // cycle 5: DECODE
    imem_ack = 1'b0;
    check("t2_ir", instr, 32'h1234_52B7);
    tick();                                    // cycle 6: EXEC
    check("t2_no_wr6", {31'd0, reg_write}, 32'd0);
    tick();                                    // cycle 7: WB
    check("t2_wr7", {31'd0, reg_write}, 32'd1);
    tick();                                    // FETCH at pc=4 (run still high)
    check("t3_addr", imem_addr, 32'h4);
    check("t3_req", {31'd0, imem_req}, 32'd1);
    imem_ack = 1'b1; imem_rdata = 32'h0000_0073;
    tick();                                    // DECODE
    imem_ack = 1'b0;
    tick();                                    // HALT
    check("t3_halted", {31'd0, halted}, 32'd1);
    check("t3_pc", pc, 32'h4);
    check("t3_retired", {16'd0, retired_count}, 32'd1);
    check("t3_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      run = i[0]; imem_ack = 1'b1; imem_rdata = 32'h1234_52B7;
      tick();
      check($sformatf("t3_stay%0d", i), {29'd0, halted, imem_req, reg_write}, 32'b100);
    end
    imem_ack = 1'b0;
    check("t3_ir_kept", instr, 32'h0000_0073);
    check("t3_pc_kept", pc, 32'h4);

    // 4: illegal opcode
    do_reset();
    run = 1'b1;
    tick();
    imem_ack = 1'b1; imem_rdata = 32'h0000_0033;
    tick();                                    // DECODE
    imem_ack = 1'b0;
    check("t4_dec_wr", {31'd0, reg_write}, 32'd0);
    tick();                                    // FAULT
    check("t4_fault", {30'd0, fault_code}, 32'd1);
    check("t4_pc", pc, 32'h0);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (reg_write) n++;
      tick();
    end
    check("t4_no_wr", n, 32'd0);
    check("t4_halted", {31'd0, halted}, 32'd0);

    // 5: fetch timeout
    do_reset();
    run = 1'b1;
    tick();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!imem_req) break;
      n++;
      tick();
    end
    check("t5_req_cycles", n, 32'd15);
    check("t5_fault", {30'd0, fault_code}, 32'd2);
    check("t5_req", {31'd0, imem_req}, 32'd0);
    check("t5_pc", pc, 32'h0);

    // 6a: reset asserted during EXEC
    do_reset();
    run = 1'b1;
    tick();
    imem_ack = 1'b1; imem_rdata = 32'h1234_52B7;
    tick();
    imem_ack = 1'b0;
    tick();                                    // EXEC
    check("t6a_exec", {31'd0, alu_src}, 32'd1);
    rst = 1'b0;
    #1;
    check("t6a_ctl", {28'd0, reg_write, alu_src, alu_op}, 32'd0);
    check("t6a_instr", instr, 32'h0);
    check("t6a_pc", pc, 32'h0);
    check("t6a_busy", {30'd0, busy, imem_req}, 32'd0);
    tick();
    check("t6a_no_wr", {31'd0, reg_write}, 32'd0);
    check("t6a_retired", {16'd0, retired_count}, 32'd0);
    rst = 1'b1; run = 1'b0;

    // 6b: pc wrap with run dropped in DECODE
    w_rst = 1'b1;
    check("t6b_rst_pc", w_pc, 32'hFFFF_FFFC);
    w_run = 1'b1;
    tick();
    check("t6b_addr", w_imem_addr, 32'hFFFF_FFFC);
    w_imem_ack = 1'b1; w_imem_rdata = 32'h1234_52B7;
    tick();                                    // DECODE
    w_imem_ack = 1'b0; w_run = 1'b0;
    tick();                                    // EXEC
    tick();                                    // WB
    check("t6b_wr", {31'd0, w_reg_write}, 32'd1);
    tick();                                    // IDLE
    check("t6b_pc", w_pc, 32'h0);
    check("t6b_retired", {16'd0, w_retired_count}, 32'd1);
    check("t6b_idle", {30'd0, w_busy, w_imem_req}, 32'd0);
    tick();
    tick();
    check("t6b_req_low", {30'd0, w_busy, w_imem_req}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lui_cpu_sequencer.md
Name: lui_cpu_sequencer

Overview:
- Multi-cycle control FSM that drives the single-instruction LUI CPU datapath.
- Fetches instructions from instruction memory over a req/ack handshake and holds them in an instruction register (IR).
- Presents the IR to the datapath and sequences FETCH/DECODE/EXEC/WB, pulsing the register-file write enable once per retired instruction.
- Owns the PC, halt/fault status and the retired-instruction counter.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- PC_STEP, 4, PC increment per retired instruction.
- FETCH_TIMEOUT, 15, max cycles imem_req may stay high without imem_ack before faulting (1..255).
- CNT_W, 16, width of retired_count.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- run  in  1  enable; sampled in IDLE and at each instruction boundary.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address (= pc).
- imem_ack  in  1  fetch complete; imem_rdata is valid this cycle.
- imem_rdata  in  32  fetched instruction word.
- instr  out  32  IR contents, fed to the datapath instr input.
- reg_write  out  1  register-file write enable.
- alu_src  out  1  ALU B-mux select (1 = immediate).
- alu_op  out  2  ALUOp to ALU control.
- pc  out  32  current PC.
- busy  out  1  high in FETCH/DECODE/EXEC/WB.
- halted  out  1  sticky; SYSTEM opcode retired.
- fault_code  out  2  sticky; 0 none, 1 illegal opcode, 2 fetch timeout.
- retired_count  out  CNT_W  LUI instructions retired.

Behaviour:
- Reset (rst=0, async):
  - State to IDLE; pc=RESET_PC; IR=0.
  - All other outputs 0, including timeout counter and retired_count.
  - Reset asserted mid-instruction aborts it; no write occurs.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT, FAULT.
- IDLE:
  - Go to FETCH when run=1.
  - busy=0; all control outputs 0.
- FETCH:
  - imem_req=1; imem_addr=pc, held stable until ack.
  - Cycle with imem_ack=1: IR <= imem_rdata; go to DECODE; imem_req=0 next cycle.
  - Timeout counter increments each FETCH cycle without ack. When the count reaches FETCH_TIMEOUT, go to FAULT with fault_code=2.
  - imem_ack outside FETCH is ignored.
- DECODE:
  - IR[6:0]=7'b0110111 (LUI) -> EXEC.
  - IR[6:0]=7'b1110011 (SYSTEM) -> HALT; halted=1.
  - Any other opcode -> FAULT with fault_code=1.
- EXEC:
  - alu_src=1, alu_op=2'b01; go to WB.
- WB:
  - alu_src=1, alu_op=2'b01, reg_write=1 for exactly one cycle.
  - x0 suppression is owned by the register file, not this block.
  - On exit: pc <= pc + PC_STEP (mod 2^32, wraps); retired_count += 1, saturating at all-ones.
  - Next state is FETCH if run=1, else IDLE.
- Deasserting run mid-instruction lets the current instruction complete; the block stops only at the WB boundary.
- HALT and FAULT:
  - Terminal; exit only via reset; run is ignored.
  - pc stays at the offending instruction; retired_count is unchanged.
  - reg_write/imem_req=0.
- Latency: 4 cycles per LUI with zero-wait memory; each imem wait cycle adds 1.
- instr output is IR at all times, stable from DECODE through WB.

Decomposition:
- Shared package: state enum, OPC_LUI, OPC_SYSTEM, ALUOP_PASS_IMM=2'b01, FAULT_NONE/ILLEGAL/TIMEOUT codes.
- One sub-module, lui_seq_fetch_if, contains:
  - req/ack handshake;
  - IR capture;
  - timeout counter, with start/done/timeout strobes back to the FSM.

Test Plan:
1. Reset, run=1, zero-wait imem returns 32'h123452B7 (LUI x5,0x12345) -> imem_addr=0; reg_write high for 1 cycle in cycle 4 with instr[11:7]=5, alu_src=1, alu_op=01; pc 0->4; retired_count=1.
2. Ack delayed 3 cycles -> imem_req and imem_addr=0 stable for 4 cycles; IR unchanged until ack; reg_write in cycle 7.
3. Fetch of 32'h00000073 after one LUI -> halted=1, pc=4, retired_count=1, busy=0; later run toggles and imem_ack ignored.
4. Fetch of 32'h00000033 -> fault_code=1, no reg_write pulse, pc unchanged.
5. imem_ack held low -> after 15 FETCH cycles: fault_code=2, imem_req=0.
6. Two parts:
   - rst low during EXEC -> all outputs return to reset values immediately, with no reg_write.
   - With RESET_PC=32'hFFFFFFFC, run dropped during DECODE -> LUI completes, pc wraps to 0, state IDLE, imem_req stays 0.
